// File: rtl/tone_req_if.sv
// Sound-request link between the game sound controller (master) and the tone player (slave).
interface tone_req_if;
  logic       req;
  logic [1:0] sound_type;
  logic       busy;
  logic       done;

  modport master (output req, output sound_type, input busy, input done);
  modport slave  (input req, input sound_type, output busy, output done);
endinterface

// File: rtl/tone_sequence_player.sv
// Plays a short square-wave note sequence chosen by a 2-bit sound type, reporting busy/done.
// Optional feature: define RETRIGGER_EN to let a new request restart a running sequence.
module tone_sequence_player #(
  parameter int CNT_W    = 24,
  parameter int HP_C     = 191113,
  parameter int HP_E     = 151685,
  parameter int HP_G     = 127551,
  parameter int HP_A     = 113636,
  parameter int NOTE_LEN = 10000000,
  parameter int GAP_LEN  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  tone_req_if.slave  req_if,
  output logic       o_audio
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(HP_C - 1);
  localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(HP_E - 1);
  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(HP_G - 1);
  localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(HP_A - 1);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(NOTE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_hp_cnt, w_hp_cnt;
  logic [CNT_W-1:0] r_len_cnt, w_len_cnt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt;
  logic [1:0]       r_note_idx, w_note_idx;
  logic [1:0]       r_type, w_type;
  logic             r_audio, w_audio;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_retrig;
  logic             w_last_note;
  logic [CNT_W-1:0] w_hp_last;

  // Sequence ROM: terminal half-period count of note idx within sound type t.
  function automatic logic [CNT_W-1:0] hp_last(input logic [1:0] t, input logic [1:0] idx);
    case ({t, idx})
      4'b00_00, 4'b00_01: hp_last = A_LAST;
      4'b01_00, 4'b01_01: hp_last = G_LAST;
      4'b10_00:           hp_last = C_LAST;
      4'b10_01:           hp_last = E_LAST;
      4'b11_00:           hp_last = C_LAST;
      4'b11_01:           hp_last = E_LAST;
      4'b11_10:           hp_last = G_LAST;
      4'b11_11:           hp_last = C_LAST;
      default:            hp_last = A_LAST;
    endcase
  endfunction

`ifdef RETRIGGER_EN
  assign w_retrig = req_if.req;
`else
  assign w_retrig = 1'b0;
`endif

  assign w_hp_last   = hp_last(r_type, r_note_idx);
  assign w_last_note = (r_type == 2'd3) ? (r_note_idx == 2'd3) : (r_note_idx == 2'd1);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    w_state    = r_state;
    w_hp_cnt   = r_hp_cnt;
    w_len_cnt  = r_len_cnt;
    w_gap_cnt  = r_gap_cnt;
    w_note_idx = r_note_idx;
    w_type     = r_type;
    w_audio    = r_audio;
    w_busy     = r_busy;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_if.req) begin
          w_state    = S_TONE;
          w_type     = req_if.sound_type;
          w_note_idx = 2'd0;
          w_hp_cnt   = CNT_ZERO;
          w_len_cnt  = CNT_ZERO;
          w_gap_cnt  = CNT_ZERO;
          w_audio    = 1'b1;
          w_busy     = 1'b1;
        end else begin
          w_audio = 1'b0;
          w_busy  = 1'b0;
        end
      end
      S_TONE: begin
        if (w_retrig) begin
          w_type     = req_if.sound_type;
          w_note_idx = 2'd0;
          w_hp_cnt   = CNT_ZERO;
          w_len_cnt  = CNT_ZERO;
          w_gap_cnt  = CNT_ZERO;
          w_audio    = 1'b1;
        end else if (r_len_cnt == LEN_LAST) begin
          w_audio = 1'b0;
          if (w_last_note) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state    = S_GAP;
            w_note_idx = r_note_idx + 2'd1;
            w_gap_cnt  = CNT_ZERO;
          end
        end else begin
          w_len_cnt = r_len_cnt + CNT_ONE;
          if (r_hp_cnt == w_hp_last) begin
            w_audio  = ~r_audio;
            w_hp_cnt = CNT_ZERO;
          end else begin
            w_hp_cnt = r_hp_cnt + CNT_ONE;
          end
        end
      end
      S_GAP: begin
        if (w_retrig) begin
          w_state    = S_TONE;
          w_type     = req_if.sound_type;
          w_note_idx = 2'd0;
          w_hp_cnt   = CNT_ZERO;
          w_len_cnt  = CNT_ZERO;
          w_gap_cnt  = CNT_ZERO;
          w_audio    = 1'b1;
        end else if (r_gap_cnt == GAP_LAST) begin
          // Every note restarts phase-aligned with the high half first.
          w_state   = S_TONE;
          w_hp_cnt  = CNT_ZERO;
          w_len_cnt = CNT_ZERO;
          w_audio   = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt + CNT_ONE;
          w_audio   = 1'b0;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_audio = 1'b0;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_audio = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hp_cnt   <= CNT_ZERO;
      r_len_cnt  <= CNT_ZERO;
      r_gap_cnt  <= CNT_ZERO;
      r_note_idx <= 2'd0;
      r_type     <= 2'd0;
      r_audio    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_hp_cnt   <= w_hp_cnt;
      r_len_cnt  <= w_len_cnt;
      r_gap_cnt  <= w_gap_cnt;
      r_note_idx <= w_note_idx;
      r_type     <= w_type;
      r_audio    <= w_audio;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign o_audio     = r_audio;
  assign req_if.busy = r_busy;
  assign req_if.done = r_done;

endmodule

// File: tb/tb_tone_sequence_player.sv
// Bench for tone_sequence_player: per-cycle comparison against a waveform-list model plus directed scenarios.
module tb_tone_sequence_player;

  localparam int NOTE_LEN = 12;
  localparam int GAP_LEN  = 4;
`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic rst;
  logic audio;
  tone_req_if bus ();

  tone_sequence_player #(
    .CNT_W(24), .HP_C(5), .HP_E(4), .HP_G(3), .HP_A(2),
    .NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_if(bus.slave),
    .o_audio(audio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected {done,busy,audio} for each cycle still to come in the current sequence.
  logic [2:0] q[$];
  logic [2:0] exp_v;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int note_hp(input int t, input int i);
    int tbl [4][4];
    tbl[0] = '{2, 2, 0, 0};   // A A
    tbl[1] = '{3, 3, 0, 0};   // G G
    tbl[2] = '{5, 4, 0, 0};   // C E
    tbl[3] = '{5, 4, 3, 5};   // C E G C
    return tbl[t][i];
  endfunction

  task automatic build(input int t);
    int n;
    int hp;
    n = (t == 3) ? 4 : 2;
    q.delete();
    for (int i = 0; i < n; i++) begin
      hp = note_hp(t, i);
      for (int c = 0; c < NOTE_LEN; c++)
        q.push_back({1'b0, 1'b1, (((c / hp) % 2) == 0)});
      if (i < n - 1)
        for (int g = 0; g < GAP_LEN; g++) q.push_back(3'b010);
    end
    q.push_back(3'b110);
  endtask

  // Reference model: advances one cycle per clock edge.
  initial begin
    exp_v = 3'b000;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        exp_v = 3'b000;
      end else begin
        if (bus.req && (!exp_v[1] || (RETRIG && !exp_v[2])))
          build(int'(bus.sound_type));
        if (q.size() > 0) exp_v = q.pop_front();
        else exp_v = 3'b000;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) check("cycle_outputs", int'({bus.done, bus.busy, audio}), int'(exp_v));
    end
  end

  task automatic run_seq(input logic [1:0] t, input int inj_k, input logic [1:0] inj_t,
                         output int busy_cyc, output int done_at, output int done_cnt,
                         output bit finished);
    busy_cyc = 0; done_at = -1; done_cnt = 0; finished = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.sound_type = t;
    @(negedge clk);
    bus.req = 1'b0; bus.sound_type = 2'($urandom_range(0, 3));
    for (int k = 1; k <= 200; k++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin done_cnt++; done_at = k; end
      if (!bus.busy && k > 1) begin finished = 1'b1; break; end
      if (k == inj_k) begin bus.req = 1'b1; bus.sound_type = inj_t; end
      else bus.req = 1'b0;
      @(negedge clk);
    end
    bus.req = 1'b0;
  endtask

  int  bc, da, dc, hi;
  bit  fin;

  initial begin
    rst = 1'b1; bus.req = 1'b0; bus.sound_type = 2'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_audio", int'(audio), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);

    // Idle with no request.
    hi = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      hi += int'(audio) + int'(bus.busy) + int'(bus.done);
    end
    check("idle_activity", hi, 0);

    // Two A notes.
    run_seq(2'd0, 0, 2'd0, bc, da, dc, fin);
    check("t0_finished", int'(fin), 1);
    check("t0_busy_cycles", bc, 29);
    check("t0_done_cycle", da, 29);
    check("t0_done_count", dc, 1);

    // Four-note win sequence.
    run_seq(2'd3, 0, 2'd0, bc, da, dc, fin);
    check("t3_finished", int'(fin), 1);
    check("t3_busy_cycles", bc, 61);
    check("t3_done_count", dc, 1);

    // Reset during the gap of the speed-round sequence.
    @(negedge clk);
    bus.req = 1'b1; bus.sound_type = 2'd2;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (13) @(negedge clk);
    check("t2_in_gap_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_audio", int'(audio), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hi += int'(bus.done) + int'(bus.busy);
    end
    check("post_rst_quiet", hi, 0);

    // Second request while the first note of type 0 plays.
    run_seq(2'd0, 5, 2'd1, bc, da, dc, fin);
    check("inj_finished", int'(fin), 1);
    check("inj_done_cycle", da, RETRIG ? 5 + 29 : 29);
    check("inj_done_count", dc, 1);

    // Randomised requests, including ones during busy and on the done/idle boundary.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus.req = ($urandom_range(0, 24) == 0);
      bus.sound_type = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus.req = 1'b0;
    repeat (80) @(negedge clk);
    check("final_idle_busy", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
